// File: rtl/apb_pkg.sv
// Shared types and constants for the CPU-side APB initiator and its strobe encoder.
package apb_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned STRB_SIZE  = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      ERR
   } apb_state_t;

   typedef enum logic [1:0] {
      BYTE     = 2'd0,
      HALFWORD = 2'd1,
      FULLWORD = 2'd2
   } apb_size_t;

endpackage

// File: rtl/apb_strb_enc.sv
// Access size + byte offset to PSTRB lane mask; flags misaligned or unsupported sizes.
module apb_strb_enc #(
   parameter int unsigned STRB_SIZE = 4
) (
   input  logic [1:0]           size,
   input  logic [1:0]           off,
   output logic [STRB_SIZE-1:0] strb,
   output logic                 illegal
);
   import apb_pkg::*;

   always_comb begin
      strb    = '0;
      illegal = 1'b0;
      case (size)
         BYTE: strb = STRB_SIZE'(1) << off;
         HALFWORD: begin
            if (off[0]) illegal = 1'b1;
            else        strb    = STRB_SIZE'(3) << off;
         end
         FULLWORD: begin
            if (off != 2'd0) illegal = 1'b1;
            else             strb    = STRB_SIZE'(15);
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/apb_master.sv
// CPU-side APB initiator: one outstanding request, SETUP/ACCESS sequencing, timeout abort and
// a single-cycle response pulse back to the CPU.
module apb_master #(
   parameter int unsigned  ADDR_WIDTH     = 32,
   parameter int unsigned  DATA_WIDTH     = 32,
   parameter int unsigned  TIMEOUT_CYCLES = 16,
   localparam int unsigned STRB_SIZE      = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_valid,
   output logic                  cpu_ready,
   input  logic                  cpu_write,
   input  logic [1:0]            cpu_size,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  sel,
   output logic                  enable,
   output logic                  write,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [STRB_SIZE-1:0]  strb,
   input  logic                  ready,
   input  logic                  slverr,
   input  logic [DATA_WIDTH-1:0] rdata
);
   import apb_pkg::*;

   localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

   apb_state_t            state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_SIZE-1:0]  strb_q;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic                  err_late_q, err_late_d;
   logic                  capture;
   logic [STRB_SIZE-1:0]  enc_strb;
   logic                  enc_illegal;

   apb_strb_enc #(
      .STRB_SIZE(STRB_SIZE)
   ) u_strb_enc (
      .size    (cpu_size),
      .off     (cpu_addr[1:0]),
      .strb    (enc_strb),
      .illegal (enc_illegal)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      capture       = 1'b0;
      cpu_ready     = 1'b0;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
      err_late_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cpu_ready = 1'b1;
            if (cpu_valid) begin
               capture = 1'b1;
               if (enc_illegal) begin
                  state_d     = ERR;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d = SETUP;
               end
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (ready) begin
               cpu_ready   = 1'b1;
               cnt_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = slverr;
               rsp_rdata_d = write_q ? '0 : rdata;
               if (cpu_valid) begin
                  capture = 1'b1;
                  // The completing response owns the next cycle, so an illegal follow-on
                  // request reports its error one cycle later, on the way out of ERR.
                  if (enc_illegal) begin
                     state_d    = ERR;
                     err_late_d = 1'b1;
                  end else begin
                     state_d = SETUP;
                  end
               end else begin
                  state_d = IDLE;
               end
            end else if (cnt_q == CntLast) begin
               state_d       = IDLE;
               cnt_d         = '0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ERR: begin
            state_d = IDLE;
            if (err_late_q) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         write_q       <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         strb_q        <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         err_late_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         err_late_q    <= err_late_d;
         if (capture) begin
            write_q <= cpu_write;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            strb_q  <= enc_strb;
         end
      end
   end

   assign sel         = (state_q == SETUP) || (state_q == ACCESS);
   assign enable      = (state_q == ACCESS);
   assign write       = write_q;
   assign addr        = addr_q;
   assign wdata       = wdata_q;
   assign strb        = strb_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a small behavioural APB memory slave.
module tb_apb_master;

   localparam int unsigned MemWords = 16;  // 64-byte slave window

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_valid, cpu_ready, cpu_write;
   logic [1:0]  cpu_size;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        rsp_valid, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        sel, enable, write;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  strb;
   logic        ready, slverr;

   always #5 clk = ~clk;

   apb_master #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_valid   (cpu_valid),
      .cpu_ready   (cpu_ready),
      .cpu_write   (cpu_write),
      .cpu_size    (cpu_size),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .sel         (sel),
      .enable      (enable),
      .write       (write),
      .addr        (addr),
      .wdata       (wdata),
      .strb        (strb),
      .ready       (ready),
      .slverr      (slverr),
      .rdata       (rdata)
   );

   // Slave: ready one cycle after enable, strobe-filtered reads, slverr outside the window.
   logic [31:0] mem [MemWords];
   logic        hold_off, mem_clr, in_range;
   logic [31:0] lane_mask;

   always_comb begin
      in_range = addr < 32'(MemWords * 4);
      for (int i = 0; i < 4; i++) lane_mask[i*8 +: 8] = {8{strb[i]}};
      rdata  = '0;
      slverr = 1'b0;
      if (sel && enable && ready) begin
         if (!in_range)   slverr = 1'b1;
         else if (!write) rdata  = mem[addr[5:2]] & lane_mask;
      end
   end

   always @(posedge clk) begin
      if (rst || hold_off) ready <= 1'b0;
      else                 ready <= sel && enable && !ready;
      if (mem_clr) begin
         for (int i = 0; i < MemWords; i++) mem[i] <= '0;
      end else if (sel && enable && ready && write && in_range) begin
         for (int i = 0; i < 4; i++)
            if (strb[i]) mem[addr[5:2]][i*8 +: 8] <= wdata[i*8 +: 8];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and follow it to its response pulse (both waits bounded).
   task automatic xfer(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er,
                       output logic to, output int lat, output int acc, output logic saw,
                       output logic [3:0] sstrb, output logic sel_at_rsp);
      cpu_valid = 1'b1;
      cpu_write = w;
      cpu_size  = sz;
      cpu_addr  = a;
      cpu_wdata = d;
      for (int i = 0; i < 20 && !cpu_ready; i++) cyc();
      check_eq("accept", 32'(cpu_ready), 32'd1);
      cyc();
      cpu_valid = 1'b0;
      lat   = 1;
      acc   = 0;
      saw   = 1'b0;
      sstrb = '0;
      while (!rsp_valid && lat < 40) begin
         if (sel) begin
            saw   = 1'b1;
            sstrb = strb;
         end
         if (sel && enable) acc++;
         cyc();
         lat++;
      end
      check_eq("rsp_seen", 32'(rsp_valid), 32'd1);
      rd         = rsp_rdata;
      er         = rsp_err;
      to         = rsp_timeout;
      sel_at_rsp = sel;
   endtask

   logic [31:0] rd;
   logic        er, to, saw, sel_r, bad_rsp;
   logic [3:0]  ss;
   int          lat, acc;

   initial begin
      rst = 1'b1; mem_clr = 1'b1; hold_off = 1'b0;
      cpu_valid = 1'b0; cpu_write = 1'b0; cpu_size = 2'd0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) cyc();
      check_eq("rst_sel", 32'(sel), 32'd0);
      check_eq("rst_enable", 32'(enable), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_strb", 32'(strb), 32'd0);
      check_eq("rst_addr", addr, 32'd0);
      rst = 1'b0; mem_clr = 1'b0;
      cyc();
      check_eq("idle_ready", 32'(cpu_ready), 32'd1);

      // FULLWORD write, cycle by cycle
      cpu_valid = 1'b1; cpu_write = 1'b1; cpu_size = 2'd2;
      cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
      cyc();
      cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      check_eq("wr_setup_sel", 32'(sel), 32'd1);
      check_eq("wr_setup_en", 32'(enable), 32'd0);
      check_eq("wr_setup_strb", 32'(strb), 32'hF);
      check_eq("wr_setup_write", 32'(write), 32'd1);
      check_eq("wr_setup_addr", addr, 32'h10);
      check_eq("wr_setup_wdata", wdata, 32'hDEADBEEF);
      cyc();
      check_eq("wr_access_en", 32'(enable), 32'd1);
      check_eq("wr_setup_no_ready", 32'(cpu_ready), 32'd0);
      cyc();
      check_eq("wr_t3_no_rsp", 32'(rsp_valid), 32'd0);
      cyc();
      check_eq("wr_t4_rsp", 32'(rsp_valid), 32'd1);
      check_eq("wr_t4_err", 32'(rsp_err), 32'd0);
      check_eq("wr_t4_to", 32'(rsp_timeout), 32'd0);
      check_eq("wr_t4_rdata", rsp_rdata, 32'd0);
      check_eq("wr_t4_sel", 32'(sel), 32'd0);
      cyc();
      check_eq("wr_t5_pulse_end", 32'(rsp_valid), 32'd0);
      check_eq("wr_mem", mem[4], 32'hDEADBEEF);

      xfer(1'b0, 2'd0, 32'h12, 32'd0, rd, er, to, lat, acc, saw, ss, sel_r);
      check_eq("byte_rd_strb", 32'(ss), 32'h4);
      check_eq("byte_rd_data", rd, 32'h00AD0000);
      check_eq("byte_rd_err", 32'(er), 32'd0);
      check_eq("byte_rd_lat", 32'(lat), 32'd4);

      xfer(1'b0, 2'd1, 32'h11, 32'd0, rd, er, to, lat, acc, saw, ss, sel_r);
      check_eq("half_mis_sel", 32'(saw), 32'd0);
      check_eq("half_mis_err", 32'(er), 32'd1);
      check_eq("half_mis_lat", 32'(lat), 32'd1);
      check_eq("half_mis_rdata", rd, 32'd0);

      xfer(1'b1, 2'd3, 32'h00, 32'hFFFFFFFF, rd, er, to, lat, acc, saw, ss, sel_r);
      check_eq("size3_sel", 32'(saw), 32'd0);
      check_eq("size3_err", 32'(er), 32'd1);

      xfer(1'b1, 2'd1, 32'h16, 32'h12340000, rd, er, to, lat, acc, saw, ss, sel_r);
      check_eq("half_wr_strb", 32'(ss), 32'hC);
      check_eq("half_wr_err", 32'(er), 32'd0);
      xfer(1'b1, 2'd0, 32'h13, 32'h77000000, rd, er, to, lat, acc, saw, ss, sel_r);
      check_eq("byte_wr_strb", 32'(ss), 32'h8);
      xfer(1'b0, 2'd2, 32'h14, 32'd0, rd, er, to, lat, acc, saw, ss, sel_r);
      check_eq("word_rd_14", rd, 32'h12340000);
      xfer(1'b0, 2'd2, 32'h10, 32'd0, rd, er, to, lat, acc, saw, ss, sel_r);
      check_eq("word_rd_10", rd, 32'h77ADBEEF);

      xfer(1'b0, 2'd2, 32'h40, 32'd0, rd, er, to, lat, acc, saw, ss, sel_r);
      check_eq("oor_err", 32'(er), 32'd1);
      check_eq("oor_to", 32'(to), 32'd0);
      check_eq("oor_rdata", rd, 32'd0);

      hold_off = 1'b1;
      xfer(1'b0, 2'd2, 32'h08, 32'd0, rd, er, to, lat, acc, saw, ss, sel_r);
      hold_off = 1'b0;
      check_eq("to_access_cycles", 32'(acc), 32'd4);
      check_eq("to_flag", 32'(to), 32'd1);
      check_eq("to_err", 32'(er), 32'd1);
      check_eq("to_rdata", rd, 32'd0);
      check_eq("to_sel_dropped", 32'(sel_r), 32'd0);
      cyc();

      // Back-to-back writes, then reset during the second ACCESS
      cpu_valid = 1'b1; cpu_write = 1'b1; cpu_size = 2'd2;
      cpu_addr = 32'h20; cpu_wdata = 32'hA5A50001;
      check_eq("b2b_idle_ready", 32'(cpu_ready), 32'd1);
      cyc();
      cpu_addr = 32'h24; cpu_wdata = 32'h5A5A0002;
      check_eq("b2b_setup_ready", 32'(cpu_ready), 32'd0);
      check_eq("b2b_setup_addr", addr, 32'h20);
      cyc();
      check_eq("b2b_access_en", 32'(enable), 32'd1);
      cyc();
      check_eq("b2b_ready_cycle", 32'(cpu_ready), 32'd1);
      cyc();
      cpu_valid = 1'b0;
      check_eq("b2b_sel_held", 32'(sel), 32'd1);
      check_eq("b2b_second_setup", 32'(enable), 32'd0);
      check_eq("b2b_second_addr", addr, 32'h24);
      check_eq("b2b_first_rsp", 32'(rsp_valid), 32'd1);
      cyc();
      check_eq("b2b_second_access", 32'(enable), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_eq("rst_mid_sel", 32'(sel), 32'd0);
      check_eq("rst_mid_en", 32'(enable), 32'd0);
      bad_rsp = rsp_valid;
      for (int i = 0; i < 6; i++) begin
         cyc();
         bad_rsp = bad_rsp | rsp_valid;
      end
      check_eq("rst_mid_no_rsp", 32'(bad_rsp), 32'd0);
      check_eq("b2b_first_mem", mem[8], 32'hA5A50001);
      check_eq("b2b_second_mem", mem[9], 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1);
   end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- CPU-side APB initiator. Accepts one CPU request at a time over a valid/ready handshake.
- Runs the APB SETUP and ACCESS phases toward apb_slave.
- Encodes the access size and address offset into a byte strobe (PSTRB), the inverse of the slave's strobe decoder.
- Returns read data, slave error or timeout to the CPU as a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 32, APB/CPU address width.
- DATA_WIDTH, 32, data width; STRB_SIZE = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles to wait for ready before aborting; legal range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_valid  in  1  request valid
- cpu_ready  out  1  request accepted this cycle
- cpu_write  in  1  1 = write, 0 = read
- cpu_size  in  2  0 = BYTE, 1 = HALFWORD, 2 = FULLWORD, 3 = illegal
- cpu_addr  in  ADDR_WIDTH  byte address
- cpu_wdata  in  DATA_WIDTH  write data, already lane-aligned
- rsp_valid  out  1  response pulse
- rsp_rdata  out  DATA_WIDTH  read data, unshifted in its lanes
- rsp_err  out  1  slverr, misaligned or illegal size
- rsp_timeout  out  1  ready never arrived
- sel  out  1  PSEL
- enable  out  1  PENABLE
- write  out  1  PWRITE
- addr  out  ADDR_WIDTH  PADDR
- wdata  out  DATA_WIDTH  PWDATA
- strb  out  STRB_SIZE  PSTRB
- ready  in  1  PREADY
- slverr  in  1  PSLVERR
- rdata  in  DATA_WIDTH  PRDATA

Behaviour:
- Reset: rst sampled on the clk edge only.
  - All outputs go to 0; state goes to IDLE; the timeout counter clears.
  - Reset asserted mid-transfer abandons the transfer with no response pulse. sel and enable are 0 on the next edge.
- Handshake: cpu_ready = 1 only in IDLE, or in ACCESS on the cycle that ready = 1.
  - A request is accepted when cpu_valid & cpu_ready.
  - Request fields are captured into registers at acceptance. The CPU may change its inputs afterwards.
- Strobe encoding, using off = cpu_addr[1:0]:
  - BYTE: strb = 1 << off.
  - HALFWORD: off 0 gives 0x3; off 2 gives 0xC.
  - FULLWORD: off 0 gives 0xF.
  - Any other combination (misaligned or size 3) is illegal.
- Illegal requests: accepted, but no bus cycle is issued. The block goes to state ERR and, on the next cycle, pulses rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- Reads drive strb with the same encoding. The slave uses it as its rdata filter.
- addr is driven full-width and unaligned bits are not cleared. Out-of-range checking is left to the slave.
- State machine, registered outputs:
  - IDLE: sel = 0, enable = 0. A legal accept goes to SETUP; an illegal accept goes to ERR.
  - SETUP: exactly 1 cycle with sel = 1, enable = 0, and addr/write/wdata/strb driven from the captured registers. Always goes to ACCESS.
  - ACCESS: sel = 1, enable = 1, all bus outputs held stable.
    - On ready = 1: rsp_valid pulses the next cycle with rsp_rdata = rdata (reads; 0 on writes) and rsp_err = slverr. rsp_timeout = 0.
    - If cpu_valid is also 1 that cycle, the new request is accepted and the block goes straight to SETUP (back-to-back, sel stays 1). Otherwise it goes to IDLE.
    - The counter increments on every ACCESS cycle with ready = 0. When the count reaches TIMEOUT_CYCLES, the block drops sel/enable, goes to IDLE and pulses rsp_valid with rsp_timeout = 1, rsp_err = 1, rsp_rdata = 0.
  - ERR: 1 cycle, then IDLE.
- Latency against the current slave (ready one cycle after enable): accept at T, SETUP at T+1, ACCESS at T+2..T+3, response at T+4.
- rsp_* outputs are valid only while rsp_valid = 1; they are 0 otherwise.
- Only one transaction is outstanding at a time. No CPU request is accepted while in SETUP.

Decomposition:
- Shared package apb_pkg:
  - apb_state_t enum {IDLE, SETUP, ACCESS, ERR}
  - apb_size_t enum {BYTE, HALFWORD, FULLWORD}
  - STRB_SIZE and DATA_WIDTH constants, added alongside the existing apb_arch.svh defines.
- One natural sub-module: apb_strb_enc, purely combinational: size + off in, strb + illegal out.
- The FSM, capture registers and timeout counter stay in apb_master.

Test Plan:
- FULLWORD write: addr 0x10, wdata 0xDEADBEEF.
  - Expect SETUP at T+1 with strb 0xF and write = 1, ACCESS at T+2.
  - Expect rsp_valid at T+4 with rsp_err = 0; memory word 0x10 reads back 0xDEADBEEF.
- BYTE read: addr 0x12 after the write above.
  - Expect strb 0x4 and rsp_rdata 0x00AD0000.
- HALFWORD request at addr 0x11.
  - Expect sel to never assert, and rsp_valid + rsp_err one cycle after accept.
- Read at addr >= MEM_SIZE.
  - Slave returns slverr; expect rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
- Responder held at ready = 0 with TIMEOUT_CYCLES = 4.
  - Expect exactly 4 ACCESS cycles, then sel = 0 and rsp_timeout = 1.
- Back-to-back: two writes with cpu_valid held high.
  - Expect ACCESS → SETUP with no IDLE cycle between them.
  - Then assert rst during the second ACCESS: expect sel/enable = 0 next cycle and no rsp_valid.
